// File: rtl/two_phase_rx.sv
// Purpose : receiver for a two-phase (toggle) req/ack link; captures DataIn per ReqT level change.
// Latency : Valid rises SYNC_STAGES edges after ReqT is first sampled at its new level; AckT toggles on the consume edge.
// Backpr. : word held (Valid=1) until Ready=1; a ReqT toggle while holding sets sticky Overrun.
// Optional: TWO_PHASE_RX_PARITY_EN adds ParIn/ParErr even-parity checking of the captured word.
module two_phase_rx #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             Clk,
    input  logic             ClrN,
    input  logic             ReqT,
    input  logic [WIDTH-1:0] DataIn,
    output logic             AckT,
    output logic [WIDTH-1:0] DataOut,
    output logic             Valid,
    input  logic             Ready,
    output logic             Overrun
`ifdef TWO_PHASE_RX_PARITY_EN
    ,
    input  logic             ParIn,
    output logic             ParErr
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_sync;
    logic                   pending;

    state_t                 state_q, state_d;
    logic                   req_seen_q, req_seen_d;
    logic                   ack_q, ack_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic                   ovr_q, ovr_d;
`ifdef TWO_PHASE_RX_PARITY_EN
    logic                   perr_q, perr_d;
`endif

    // ReqT crosses into the Clk domain through a plain flop chain.
    always_ff @(posedge Clk or negedge ClrN) begin
        if (!ClrN) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ReqT};
        end
    end

    assign req_sync = sync_q[SYNC_STAGES-1];
    assign pending  = (req_sync != req_seen_q);

    // State and datapath registers.
    always_ff @(posedge Clk or negedge ClrN) begin
        if (!ClrN) begin
            state_q    <= IDLE;
            req_seen_q <= 1'b0;
            ack_q      <= 1'b0;
            data_q     <= '0;
            ovr_q      <= 1'b0;
`ifdef TWO_PHASE_RX_PARITY_EN
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            req_seen_q <= req_seen_d;
            ack_q      <= ack_d;
            data_q     <= data_d;
            ovr_q      <= ovr_d;
`ifdef TWO_PHASE_RX_PARITY_EN
            perr_q     <= perr_d;
`endif
        end
    end

    // Next-state: capture from IDLE on a pending toggle, release from HOLD on Ready.
    always_comb begin
        state_d    = state_q;
        req_seen_d = req_seen_q;
        ack_d      = ack_q;
        data_d     = data_q;
        ovr_d      = ovr_q;
`ifdef TWO_PHASE_RX_PARITY_EN
        perr_d     = perr_q;
`endif
        case (state_q)
            IDLE: begin
                if (pending) begin
                    data_d     = DataIn;
                    req_seen_d = req_sync;
                    state_d    = HOLD;
`ifdef TWO_PHASE_RX_PARITY_EN
                    perr_d     = (^DataIn) ^ ParIn;
`endif
                end
            end
            HOLD: begin
                // A new toggle while a word is held is a sender protocol violation.
                if (pending) begin
                    ovr_d = 1'b1;
                end
                if (Ready) begin
                    ack_d   = ~ack_q;
                    state_d = IDLE;
`ifdef TWO_PHASE_RX_PARITY_EN
                    perr_d  = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign Valid   = (state_q == HOLD);
    assign AckT    = ack_q;
    assign DataOut = data_q;
    assign Overrun = ovr_q;
`ifdef TWO_PHASE_RX_PARITY_EN
    assign ParErr  = perr_q;
`endif

endmodule
